// File: rtl/score_display.sv
// Binary score -> saturated 4-digit BCD (sequential double dabble) -> multiplexed
// common-anode seven-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module score_display #(
    parameter int SCORE_W     = 16,
    parameter int REFRESH_DIV = 100000,
    parameter int SAT_VALUE   = 9999
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    output logic [3:0]         an,
    output logic [6:0]         seg,
    output logic               dp,
    output logic               busy,
    output logic               bcd_valid
);

    localparam int CNT_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BIN_W  = 14;
    localparam int SHIFTS = 14;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    state_t              state_q, state_d;
    logic [SCORE_W-1:0]  last_score_q, last_score_d;
    logic                ovf_q, ovf_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [15:0]         bcd_q, bcd_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [15:0]         digits_q, digits_d;
    logic                busy_q, busy_d;
    logic                bcd_valid_q, bcd_valid_d;

    logic [CNT_W-1:0]    refresh_q, refresh_d;
    logic [1:0]          sel_q, sel_d;
    logic [3:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;

    logic [15:0]         bcd_adj;
    logic [BIN_W-1:0]    score_sat;
    logic                score_ovf;
    logic [3:0]          cur_digit;
    logic                blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Saturation happens before the shift register, so 14 bits always suffice.
    always_comb begin
        score_ovf = (score > SCORE_W'(SAT_VALUE));
        score_sat = score_ovf ? BIN_W'(SAT_VALUE) : BIN_W'(score);
    end

    always_comb begin
        bcd_adj = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
        end
    end

    always_comb begin
        state_d      = state_q;
        last_score_d = last_score_q;
        ovf_d        = ovf_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        bit_cnt_d    = bit_cnt_q;
        digits_d     = digits_q;
        busy_d       = busy_q;
        bcd_valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (score != last_score_q) begin
                    last_score_d = score;
                    ovf_d        = score_ovf;
                    bin_d        = score_sat;
                    bcd_d        = '0;
                    bit_cnt_d    = '0;
                    state_d      = CONV;
                    busy_d       = 1'b1;
                end
            end
            CONV: begin
                busy_d         = 1'b1;
                {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
                if (bit_cnt_q == 4'(SHIFTS - 1)) begin
                    state_d     = LOAD;
                    bcd_valid_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            LOAD: begin
                digits_d = bcd_q;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            sel_d     = sel_q + 2'd1;
        end else begin
            refresh_d = refresh_q + CNT_W'(1);
            sel_d     = sel_q;
        end
    end

    always_comb begin
        cur_digit = digits_q[4*sel_q +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        // A slot blanks only when it and every more-significant digit are zero.
        case (sel_q)
            2'd3:    blank = (digits_q[15:12] == 4'd0);
            2'd2:    blank = (digits_q[15:8] == 8'd0);
            2'd1:    blank = (digits_q[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        an_d  = ~(4'b0001 << sel_q);
        seg_d = blank ? 7'b1111111 : seg_decode(cur_digit);
        dp_d  = ~((sel_q == 2'd0) && ovf_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_score_q <= '0;
            ovf_q        <= 1'b0;
            bin_q        <= '0;
            bcd_q        <= '0;
            bit_cnt_q    <= '0;
            digits_q     <= '0;
            busy_q       <= 1'b0;
            bcd_valid_q  <= 1'b0;
            refresh_q    <= '0;
            sel_q        <= '0;
            an_q         <= 4'b1110;
            seg_q        <= 7'b1000000;
            dp_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_score_q <= last_score_d;
            ovf_q        <= ovf_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            bit_cnt_q    <= bit_cnt_d;
            digits_q     <= digits_d;
            busy_q       <= busy_d;
            bcd_valid_q  <= bcd_valid_d;
            refresh_q    <= refresh_d;
            sel_q        <= sel_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign busy      = busy_q;
    assign bcd_valid = bcd_valid_q;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display with REFRESH_DIV=4; expected display
// contents come from decimal arithmetic on the applied score.
module tb_score_display;

    logic        clk;
    logic        reset;
    logic [15:0] score;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;
    logic        bcd_valid;

    int checks = 0;
    int errors = 0;

    score_display #(
        .SCORE_W    (16),
        .REFRESH_DIV(4),
        .SAT_VALUE  (9999)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .score    (score),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .busy     (busy),
        .bcd_valid(bcd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] pattern(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int pow10(input int n);
        int p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    // Shown value is the score clamped to 9999; slot i shows decimal digit i.
    function automatic logic [6:0] exp_seg(input int v, input int slot);
        int sat = (v > 9999) ? 9999 : v;
        int p   = pow10(slot);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && sat < p) return 7'b1111111;
`endif
        return pattern((sat / p) % 10);
    endfunction

    function automatic logic exp_dp(input int v, input int slot);
        return !(slot == 0 && v > 9999);
    endfunction

    function automatic int low_count(input logic [3:0] a);
        int n = 0;
        for (int k = 0; k < 4; k++) if (a[k] == 1'b0) n++;
        return n;
    endfunction

    function automatic int low_idx(input logic [3:0] a);
        for (int k = 0; k < 4; k++) if (a[k] == 1'b0) return k;
        return 0;
    endfunction

    task automatic test_reset();
        int pulses = 0;
        int busy_seen = 0;
        reset = 1'b1;
        score = 16'd0;
        repeat (3) tick();
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_an: got %b want 1110", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg: got %b want 1000000", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", dp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (bcd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bcd_valid); end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bcd_valid === 1'b1) pulses++;
            if (busy === 1'b1) busy_seen++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL idle_no_pulse: got %0d pulses want 0", pulses); end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL idle_no_busy: got %0d busy cycles want 0", busy_seen); end
    endtask

    task automatic test_latency();
        int first = -1;
        int pulses = 0;
        int v = 1234;
        score = 16'(v);
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy: got %b want 1", busy); end
        for (int i = 2; i <= 20; i++) begin
            tick();
            if (bcd_valid === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        checks++; if (first != 15) begin errors++; $display("FAIL lat_pulse_cycle: got %0d want 15", first); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL lat_pulse_count: got %0d want 1", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_busy_end: got %b want 0", busy); end
        for (int c = 0; c < 16; c++) begin
            tick();
            checks++; if (low_count(an) != 1) begin errors++; $display("FAIL lat_an_onehot: got %b want one low bit", an); end
            checks++; if (seg !== exp_seg(v, low_idx(an))) begin errors++; $display("FAIL lat_seg slot%0d: got %b want %b", low_idx(an), seg, exp_seg(v, low_idx(an))); end
            checks++; if (dp !== exp_dp(v, low_idx(an))) begin errors++; $display("FAIL lat_dp: got %b want %b", dp, exp_dp(v, low_idx(an))); end
        end
    endtask

    task automatic test_saturation();
        int vals[2] = '{65535, 17};
        for (int n = 0; n < 2; n++) begin
            int lat = -1;
            score = 16'(vals[n]);
            for (int i = 1; i <= 40 && lat < 0; i++) begin
                tick();
                if (bcd_valid === 1'b1) lat = i;
            end
            checks++; if (lat != 15) begin errors++; $display("FAIL sat_pulse_cycle v=%0d: got %0d want 15", vals[n], lat); end
            repeat (2) tick();
            for (int c = 0; c < 16; c++) begin
                tick();
                checks++; if (low_count(an) != 1) begin errors++; $display("FAIL sat_an_onehot: got %b want one low bit", an); end
                checks++; if (seg !== exp_seg(vals[n], low_idx(an))) begin errors++; $display("FAIL sat_seg v=%0d slot%0d: got %b want %b", vals[n], low_idx(an), seg, exp_seg(vals[n], low_idx(an))); end
                checks++; if (dp !== exp_dp(vals[n], low_idx(an))) begin errors++; $display("FAIL sat_dp v=%0d slot%0d: got %b want %b", vals[n], low_idx(an), dp, exp_dp(vals[n], low_idx(an))); end
            end
        end
    endtask

    task automatic test_refresh();
        logic [3:0] hist[24];
        int t0 = -1;
        for (int t = 0; t < 24; t++) begin
            tick();
            hist[t] = an;
            checks++; if (low_count(an) != 1) begin errors++; $display("FAIL ref_onehot t=%0d: got %b want one low bit", t, an); end
        end
        for (int t = 1; t < 24 && t0 < 0; t++) if (hist[t] !== hist[t-1]) t0 = t;
        checks++; if (t0 < 0 || t0 > 4) begin errors++; $display("FAIL ref_first_change: got %0d want 1..4", t0); end
        if (t0 > 0) begin
            checks++;
            if (low_idx(hist[t0]) != (low_idx(hist[t0-1]) + 1) % 4) begin
                errors++; $display("FAIL ref_step: got %b after %b", hist[t0], hist[t0-1]);
            end
            for (int t = t0; t < 24; t++) begin
                int want = (low_idx(hist[t0]) + (t - t0) / 4) % 4;
                checks++;
                if (hist[t] !== ~(4'b0001 << want)) begin
                    errors++; $display("FAIL ref_seq t=%0d: got %b want %b", t, hist[t], ~(4'b0001 << want));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int v = 5555;
        int lat = -1;
        int pulses = 0;
        score = 16'(v);
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bcd_valid === 1'b1) pulses++;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++; if (bcd_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", bcd_valid); end
        reset = 1'b0;
        tick();
        if (bcd_valid === 1'b1) pulses++;
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rmid_an: got %b want 1110", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL rmid_digits_cleared: got %b want 1000000", seg); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rmid_no_commit: got %0d pulses want 0", pulses); end
        for (int i = 2; i <= 40 && lat < 0; i++) begin
            tick();
            if (bcd_valid === 1'b1) lat = i;
        end
        checks++; if (lat != 15) begin errors++; $display("FAIL rmid_reconvert: got %0d want 15", lat); end
        repeat (2) tick();
        for (int c = 0; c < 16; c++) begin
            tick();
            checks++; if (seg !== exp_seg(v, low_idx(an))) begin errors++; $display("FAIL rmid_seg slot%0d: got %b want %b", low_idx(an), seg, exp_seg(v, low_idx(an))); end
            checks++; if (dp !== exp_dp(v, low_idx(an))) begin errors++; $display("FAIL rmid_dp: got %b want %b", dp, exp_dp(v, low_idx(an))); end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int p1 = -1;
        int p2 = -1;
        score = 16'd100;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 5) score = 16'd200;
            if (bcd_valid === 1'b1) begin
                pulses++;
                if (p1 < 0) p1 = i; else if (p2 < 0) p2 = i;
            end
            if (p1 > 0 && i >= p1 + 2 && i <= p1 + 12) begin
                checks++;
                if (seg !== exp_seg(100, low_idx(an))) begin
                    errors++; $display("FAIL b2b_first_seg slot%0d: got %b want %b", low_idx(an), seg, exp_seg(100, low_idx(an)));
                end
            end
            if (p2 > 0 && i >= p2 + 3) begin
                checks++;
                if (seg !== exp_seg(200, low_idx(an))) begin
                    errors++; $display("FAIL b2b_second_seg slot%0d: got %b want %b", low_idx(an), seg, exp_seg(200, low_idx(an)));
                end
            end
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
        checks++; if (p1 != 15) begin errors++; $display("FAIL b2b_first_cycle: got %0d want 15", p1); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int v;
            int lat = -1;
            if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 9999));
            else v = int'($urandom_range(0, 65535));
            if (16'(v) == score) v = (v + 1) % 65536;
            score = 16'(v);
            for (int i = 1; i <= 40 && lat < 0; i++) begin
                tick();
                if (bcd_valid === 1'b1) lat = i;
            end
            checks++; if (lat != 15) begin errors++; $display("FAIL rnd_pulse v=%0d: got %0d want 15", v, lat); end
            repeat (2) tick();
            for (int c = 0; c < 16; c++) begin
                tick();
                checks++; if (low_count(an) != 1) begin errors++; $display("FAIL rnd_an_onehot: got %b want one low bit", an); end
                checks++; if (seg !== exp_seg(v, low_idx(an))) begin errors++; $display("FAIL rnd_seg v=%0d slot%0d: got %b want %b", v, low_idx(an), seg, exp_seg(v, low_idx(an))); end
                checks++; if (dp !== exp_dp(v, low_idx(an))) begin errors++; $display("FAIL rnd_dp v=%0d slot%0d: got %b want %b", v, low_idx(an), dp, exp_dp(v, low_idx(an))); end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        score = 16'd0;
        test_reset();
        test_latency();
        test_saturation();
        test_refresh();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
